qmem_sram: RTL and testbench
============================

# qmem_sram

On-chip SRAM slave for the qmem bus: the target that directly consumes the transfers a bus master drives and a qmem monitor observes. It decodes a byte address into a word index and applies per-lane byte writes. Completion is signalled by `ack` (or `err`) after a parameterised number of wait states. Read data is returned one cycle after the acknowledge, matching qmem read-data timing.

## Interface
- `QAW`, 32, qmem address width (byte address).
- `QDW`, 32, qmem data width.
- `QSW`, QDW/8, number of byte-select lanes.
- `MAW`, 10, memory word-address width; depth is 2**MAW words.
- `WS`, 0, wait states inserted before `ack`/`err` (0..15).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cs`  in  1  chip select; the master holds it and all request fields stable until `ack` or `err`.
- `we`  in  1  1 = write, 0 = read.
- `sel`  in  QSW  byte-lane enables.
- `adr`  in  QAW  byte address.
- `dat_w`  in  QDW  write data.
- `dat_r`  out  QDW  read data; valid the cycle after a read `ack`, held until the next read `ack`.
- `ack`  out  1  transfer complete, combinational from `cs` and the wait counter.
- `err`  out  1  transfer rejected; same timing as `ack`, never asserted together with it.

## Operation
- Word index = `adr[MAW+log2(QSW)-1 : log2(QSW)]`.
- Byte lanes below `log2(QSW)` are ignored; lane selection comes from `sel` only.
- Wait counter `wcnt` is 4 bits. FSM states:
  - IDLE: `wcnt` = 0.
  - WAIT: `cs` high and `wcnt` < WS; `wcnt` increments each cycle.
  - DONE: `cs` high and `wcnt` == WS; `ack` (or `err`) is asserted for exactly this cycle.
- After DONE, `wcnt` returns to 0.
  - If `cs` is still high on the next cycle, a new transfer starts; back-to-back transfers are allowed with no idle cycle.
  - With WS = 0, every cycle with `cs` high is a DONE cycle, giving one transfer per clock.
- `cs` dropping during WAIT (protocol violation): `wcnt` clears to 0, no access is performed, no `ack`/`err`.
- Write, at the DONE edge with `we`=1: for each `sel[i]`=1, byte i of the word is written from `dat_w`. `sel`=0 completes with `ack` but changes nothing.
- Read, at the DONE edge with `we`=0: the full word is registered into `dat_r`; `sel` does not mask read data.
- A write never changes `dat_r`.
- A read and a write to the same word in consecutive DONE cycles: the read returns the written value (the write completes at an earlier edge).
- Reset:
  - Clears `wcnt`, `dat_r` (to 0) and the FSM state (to IDLE).
  - `ack`/`err` are forced to 0 while `rst` is high.
  - Memory contents are not reset.
  - Reset in the middle of a WAIT aborts the transfer; the master re-issues it.

## Timing
- Latency from `cs` rising to `ack`: WS cycles. `ack` appears in the cycle `cs` rises when WS = 0.
- Read data: `dat_r` is valid in cycle DONE+1.
- Throughput: one transfer every WS+1 cycles.
- `ack`/`err` have a combinational path from `cs`; all other outputs are registered.

## Configuration
- `QMEM_SRAM_ERR_EN` defined:
  - A request whose `adr` bits above the word index are non-zero gets `err` at DONE instead of `ack`.
  - No write occurs and `dat_r` is unchanged.
- Not defined: upper address bits are ignored (addresses alias modulo the memory size) and `err` is tied to 0.

## Structure
- Shared package `qmem_pkg` holds:
  - default widths `QAW`/`QDW`;
  - the FSM state encoding (IDLE/WAIT/DONE);
  - `QMEM_WCNT_W` = 4.
- Sub-module `qmem_sram_ram`: single-port, byte-enable synchronous RAM (`clk`, `en`, `we`, `be`, `addr`, `wdat`, `rdat`). The top holds the FSM, wait counter, address decode and error logic.

## Test plan
- Single access, WS=0: write 0xDEADBEEF to 0x10 with `sel`=F, `ack` in the same cycle; then read 0x10 → `ack` on the request cycle, `dat_r`=0xDEADBEEF on the next cycle.
- Byte lanes: write 0x11223344 to 0x20 with `sel`=F, then 0xAABBCCDD with `sel`=5; read 0x20 → 0x11BB33DD.
- WS=3: `cs` held → `ack` on the 4th cycle only. Back-to-back writes to 0x0 and 0x4 followed by reads of both → 4-cycle spacing, correct data.
- Abort: WS=3, `cs` dropped after 2 cycles → no `ack`, memory unchanged. Reissued request → `ack` after the full 3 wait states.
- Reset: assert `rst` mid-WAIT → `ack`=0, `dat_r`=0 on the next cycle; data written before reset still reads back.
- MAW=10, `QMEM_SRAM_ERR_EN` defined: write to 0x1000 → `err`=1, `ack`=0; read 0x0000 shows no alias write. Macro undefined: the same write aliases to 0x0000 with `ack`.

Source files
------------

// File: rtl/qmem_pkg.sv
//------------------------------------------------------------------------------
// Module  : qmem_pkg
// Purpose : Shared qmem bus widths, wait-counter width and slave FSM encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package qmem_pkg;

    localparam int QMEM_QAW    = 32;
    localparam int QMEM_QDW    = 32;
    localparam int QMEM_WCNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } qmem_state_e;

endpackage

`default_nettype wire

// File: rtl/qmem_sram_ram.sv
//------------------------------------------------------------------------------
// Module  : qmem_sram_ram
// Purpose : Single-port synchronous RAM with per-byte write enables.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module qmem_sram_ram #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int BW = DW / 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [BW-1:0] be,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdat,
    output logic [DW-1:0] rdat
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdat;

    // Read port only updates on a read, so rdat holds between reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BW; i++) begin
                    if (be[i]) begin
                        r_mem[addr][i*8 +: 8] <= wdat[i*8 +: 8];
                    end
                end
            end else begin
                r_rdat <= r_mem[addr];
            end
        end
    end

    assign rdat = r_rdat;

endmodule

`default_nettype wire

// File: rtl/qmem_sram.sv
//------------------------------------------------------------------------------
// Module  : qmem_sram
// Purpose : qmem bus SRAM slave with WS wait states and byte-lane writes.
//           Optional QMEM_SRAM_ERR_EN: out-of-range addresses complete with err.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module qmem_sram
    import qmem_pkg::*;
#(
    parameter int QAW = QMEM_QAW,
    parameter int QDW = QMEM_QDW,
    parameter int QSW = QDW / 8,
    parameter int MAW = 10,
    parameter int WS  = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cs,
    input  logic           we,
    input  logic [QSW-1:0] sel,
    input  logic [QAW-1:0] adr,
    input  logic [QDW-1:0] dat_w,
    output logic [QDW-1:0] dat_r,
    output logic           ack,
    output logic           err
);

    localparam int                     c_LSB = $clog2(QSW);
    localparam logic [QMEM_WCNT_W-1:0] c_WS  = QMEM_WCNT_W'(WS);

    logic [QMEM_WCNT_W-1:0] r_wcnt;
    logic                   r_rd_valid;
    qmem_state_e            w_state;
    logic                   w_done;
    logic                   w_hi_bad;
    logic                   w_ram_en;
    logic [MAW-1:0]         w_widx;
    logic [QDW-1:0]         w_rdat;
    logic                   w_unused_adr;

    // DONE is decoded live from cs so ack can appear in the request cycle.
    always_comb begin
        w_state = ST_IDLE;
        if (cs) begin
            w_state = (r_wcnt == c_WS) ? ST_DONE : ST_WAIT;
        end
    end

    assign w_done = (w_state == ST_DONE) && !rst;
    assign w_widx = adr[MAW+c_LSB-1:c_LSB];

`ifdef QMEM_SRAM_ERR_EN
    assign w_hi_bad     = |adr[QAW-1:MAW+c_LSB];
    assign err          = w_done && w_hi_bad;
    assign w_unused_adr = |adr[c_LSB-1:0];
`else
    assign w_hi_bad     = 1'b0;
    assign err          = 1'b0;
    assign w_unused_adr = |{adr[QAW-1:MAW+c_LSB], adr[c_LSB-1:0]};
`endif

    assign ack      = w_done && !w_hi_bad;
    assign w_ram_en = ack;

    always_ff @(posedge clk) begin
        if (rst || (w_state != ST_WAIT)) begin
            r_wcnt <= '0;
        end else begin
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    // RAM contents survive reset, so dat_r is masked until the first read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else if (ack && !we) begin
            r_rd_valid <= 1'b1;
        end
    end

    qmem_sram_ram #(
        .AW (MAW),
        .DW (QDW),
        .BW (QSW)
    ) u_ram (
        .clk  (clk),
        .en   (w_ram_en),
        .we   (we),
        .be   (sel),
        .addr (w_widx),
        .wdat (dat_w),
        .rdat (w_rdat)
    );

    assign dat_r = r_rd_valid ? w_rdat : '0;

endmodule

`default_nettype wire

// File: tb/tb_qmem_sram.sv
//------------------------------------------------------------------------------
// Module  : tb_qmem_sram
// Purpose : Scoreboard bench for qmem_sram, WS=0 and WS=3 instances.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_qmem_sram;

    typedef struct packed {
        logic        is_err;
        logic [31:0] dat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cs    [2];
    logic        we    [2];
    logic [3:0]  sel   [2];
    logic [31:0] adr   [2];
    logic [31:0] dat_w [2];
    logic [31:0] dat_r [2];
    logic        ack   [2];
    logic        err   [2];

    int          n_cmp;
    int          n_bad;
    exp_t        sbq      [2][$];
    logic [31:0] mdl      [2][1024];
    logic [31:0] last_rd  [2];
    bit          chk_pend [2];
    logic [31:0] pend_dat [2];

    qmem_sram #(.MAW(10), .WS(0)) u_dut0 (
        .clk(clk), .rst(rst), .cs(cs[0]), .we(we[0]), .sel(sel[0]), .adr(adr[0]),
        .dat_w(dat_w[0]), .dat_r(dat_r[0]), .ack(ack[0]), .err(err[0])
    );

    qmem_sram #(.MAW(10), .WS(3)) u_dut3 (
        .clk(clk), .rst(rst), .cs(cs[1]), .we(we[1]), .sel(sel[1]), .adr(adr[1]),
        .dat_w(dat_w[1]), .dat_r(dat_r[1]), .ack(ack[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h, required %h", name, d, act, req);
        end
    endtask

    // Monitor: every ack/err pops one expectation; dat_r is checked a cycle later.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (chk_pend[d]) begin
                check("dat_r", d, dat_r[d], pend_dat[d]);
                chk_pend[d] = 1'b0;
            end
            if (ack[d] || err[d]) begin
                if (sbq[d].size() == 0) begin
                    check("unexpected_resp", d, {30'd0, ack[d], err[d]}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq[d].pop_front();
                    check("ack_err", d, {30'd0, ack[d], err[d]}, {30'd0, !e.is_err, e.is_err});
                    chk_pend[d] = 1'b1;
                    pend_dat[d] = e.dat;
                end
            end
        end
    end

    // Reference: address decode and byte-lane write rules applied to a word array.
    task automatic xfer(input int d, input bit w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] dw);
        int   widx;
        bit   bad;
        exp_t e;
        int   n;
        widx = int'((a >> 2) & 32'd1023);
        bad  = 1'b0;
`ifdef QMEM_SRAM_ERR_EN
        bad  = ((a >> 12) != 0);
`endif
        if (!bad) begin
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) mdl[d][widx][i*8 +: 8] = dw[i*8 +: 8];
                end
            end else begin
                last_rd[d] = mdl[d][widx];
            end
        end
        e.is_err = bad;
        e.dat    = last_rd[d];
        sbq[d].push_back(e);
        cs[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dat_w[d] = dw;
        n = 0;
        @(negedge clk);
        while (!(ack[d] || err[d]) && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("latency", d, n, (d == 0) ? 32'd0 : 32'd3);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d, input int k);
        cs[d] = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cs[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0; adr[d] = '0; dat_w[d] = '0;
            last_rd[d] = '0; chk_pend[d] = 1'b0; pend_dat[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_resp", d, {30'd0, ack[d], err[d]}, 32'd0);
            check("reset_dat_r", d, dat_r[d], 32'd0);
        end
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) xfer(d, 1'b1, 4'hF, 32'(i * 4), $urandom);
            idle(d, 1);
        end

        // Single access and byte lanes, WS=0.
        xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        xfer(0, 1'b0, 4'hF, 32'h10, 32'h0);
        idle(0, 0);
        @(negedge clk);
        check("read_deadbeef", 0, dat_r[0], 32'hDEADBEEF);
        @(posedge clk); #1;
        xfer(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
        xfer(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD);
        xfer(0, 1'b0, 4'h0, 32'h20, 32'h0);
        idle(0, 0);
        @(negedge clk);
        check("byte_lanes", 0, dat_r[0], 32'h11BB33DD);
        @(posedge clk); #1;
        xfer(0, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
        xfer(0, 1'b0, 4'hF, 32'h0, 32'h0);
        idle(0, 2);

        // WS=3: back-to-back writes then reads.
        xfer(1, 1'b1, 4'hF, 32'h0, 32'h01020304);
        xfer(1, 1'b1, 4'hF, 32'h4, 32'hA5A5F0F0);
        xfer(1, 1'b0, 4'hF, 32'h0, 32'h0);
        xfer(1, 1'b0, 4'hF, 32'h4, 32'h0);
        idle(1, 2);

        // Abort after two wait cycles; nothing pushed, so any ack is flagged.
        cs[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h0; dat_w[1] = 32'hBAD0BAD0;
        repeat (2) @(posedge clk);
        #1;
        idle(1, 2);
        xfer(1, 1'b0, 4'hF, 32'h0, 32'h0);
        idle(1, 2);

        // Reset mid-WAIT on dut3 while dut0 holds cs high.
        cs[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h4; dat_w[1] = 32'h0BADF00D;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cs[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; adr[0] = 32'h8; dat_w[0] = 32'h0BADF00D;
        @(negedge clk);
        check("rst_ack_forced", 0, {30'd0, ack[0], err[0]}, 32'd0);
        check("rst_ack_wait", 1, {30'd0, ack[1], err[1]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; cs[0] = 1'b0; cs[1] = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        @(negedge clk);
        check("rst_dat_r", 0, dat_r[0], 32'd0);
        check("rst_dat_r", 1, dat_r[1], 32'd0);
        @(posedge clk); #1;
        xfer(1, 1'b0, 4'hF, 32'h4, 32'h0);
        xfer(0, 1'b0, 4'hF, 32'h8, 32'h0);
        idle(0, 1);
        idle(1, 1);

        // Randomized traffic, including upper-address (alias or err) requests.
        for (int d = 0; d < 2; d++) begin
            repeat (150) begin
                logic [31:0] a;
                a = ({30'd0, 2'($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0)} << 12)
                  | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                xfer(d, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
                if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
            end
            idle(d, 2);
        end

        repeat (3) @(posedge clk);
        check("sb_drain", 0, sbq[0].size(), 32'd0);
        check("sb_drain", 1, sbq[1].size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
